aes_state_loader: RTL and testbench

Sequential controller that assembles a 128-bit AES state from a byte stream by driving a byte-lane insert unit, one byte per accepted transfer, into four 32-bit SIMD lanes. It sits between the byte-wide input path and the SIMD AES datapath: it owns the byte counter, selects the target lane and byte index for each insert, and presents the completed state with a valid/ready handshake. A flush input closes a partial block with zero padding.

---
 rtl/simd_pkg.sv | 22 ++
 rtl/aes_state_loader_byte_insert.sv | 20 ++
 rtl/aes_state_loader.sv | 96 +++++++++
 tb/tb_aes_state_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD AES state path.
// Lane layout: lane w occupies bits [LANE_W*w +: LANE_W] of the packed state.
package simd_pkg;

    localparam int LANE_W         = 32;
    localparam int N_LANES        = 4;
    localparam int BYTES_PER_LANE = LANE_W / 8;
    localparam int BLOCK_BYTES    = N_LANES * BYTES_PER_LANE;
    localparam int CNT_W          = 4;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

    typedef logic [N_LANES-1:0][LANE_W-1:0] simd_state_t;

    function automatic logic is_last_byte(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(BLOCK_BYTES - 1);
    endfunction

endpackage

// File: rtl/aes_state_loader_byte_insert.sv
// Combinational byte-lane insert: replaces byte `indice` of a lane with `dato`.
module byte_insert
    import simd_pkg::*;
(
    input  logic [LANE_W-1:0] original,
    input  logic [7:0]        dato,
    input  logic [1:0]        indice,
    output logic [LANE_W-1:0] result
);

    always_comb begin
        result = original;
        for (int p = 0; p < BYTES_PER_LANE; p++) begin
            if (indice == p[1:0]) begin
                result[8*p +: 8] = dato;
            end
        end
    end

endmodule

// File: rtl/aes_state_loader.sv
// Assembles a 128-bit AES state from a byte stream, one byte per accepted
// transfer, and hands the completed block over with a valid/ready handshake.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   FILL  | accepting bytes; byte_cnt selects lane/byte; flush closes early
//   FULL  | block complete and held; waits for state_ready to hand off
module aes_state_loader
    import simd_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [7:0]                  in_byte,
    input  logic                        flush,
    output logic                        state_valid,
    input  logic                        state_ready,
    output logic [N_LANES*LANE_W-1:0]   state_data,
    output logic [CNT_W-1:0]            byte_cnt
);

    loader_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    simd_state_t       data_q, data_d;
    logic              in_ready_q;
    logic              state_valid_q;
    logic              xfer;
    logic [LANE_W-1:0] lane_cur;
    logic [LANE_W-1:0] lane_new;

    assign lane_cur = data_q[cnt_q[3:2]];

    byte_insert u_byte_insert (
        .original (lane_cur),
        .dato     (in_byte),
        .indice   (cnt_q[1:0]),
        .result   (lane_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            cnt_q         <= '0;
            data_q        <= '0;
            in_ready_q    <= 1'b1;
            state_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            in_ready_q    <= (state_d == FILL);
            state_valid_q <= (state_d == FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        xfer    = in_valid && in_ready_q;

        case (state_q)
            FILL: begin
                if (xfer) begin
                    data_d[cnt_q[3:2]] = lane_new;
                    cnt_d              = cnt_q + 4'd1;
                end
                // A same-cycle byte lands before the block closes; an empty
                // flush with nothing to close is dropped.
                if ((xfer && is_last_byte(cnt_q)) ||
                    (flush && ((cnt_q != '0) || xfer))) begin
                    state_d = FULL;
                    cnt_d   = '0;
                end
            end
            FULL: begin
                if (state_ready) begin
                    state_d = FILL;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = '0;
                data_d  = '0;
            end
        endcase
    end

    assign in_ready    = in_ready_q;
    assign state_valid = state_valid_q;
    assign state_data  = data_q;
    assign byte_cnt    = cnt_q;

endmodule

// File: tb/tb_aes_state_loader.sv
// Self-checking bench for aes_state_loader: byte-array reference model with a
// block scoreboard, a vector table for flush handling, and multi-cycle sequences.
module tb_aes_state_loader;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_byte;
    logic         flush;
    logic         state_valid;
    logic         state_ready;
    logic [127:0] state_data;
    logic [3:0]   byte_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    aes_state_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_byte     (in_byte),
        .flush       (flush),
        .state_valid (state_valid),
        .state_ready (state_ready),
        .state_data  (state_data),
        .byte_cnt    (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: bytes stored by stream position, packed at byte k -> bits [8k+7:8k]
    logic [7:0]   m_bytes [16];
    int           m_cnt;
    logic         m_full;
    logic [127:0] sb_q [$];
    logic         prev_sv;

    typedef struct {
        logic         v;
        logic [7:0]   b;
        logic         f;
        logic         sr;
        logic         exp_sv;
        logic [3:0]   exp_cnt;
        logic         chk_d;
        logic [127:0] exp_d;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] m_pack();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = m_bytes[i];
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_bytes[i] = 8'h00;
        m_cnt  = 0;
        m_full = 1'b0;
    endtask

    task automatic m_update(input logic v, input logic [7:0] b, input logic f, input logic sr);
        logic close;
        if (!m_full) begin
            close = (v && m_cnt == 15) || (f && (m_cnt != 0 || v));
            if (v) begin
                m_bytes[m_cnt] = b;
                m_cnt = (m_cnt + 1) % 16;
            end
            if (close) begin
                m_full = 1'b1;
                m_cnt  = 0;
                sb_q.push_back(m_pack());
            end
        end else if (sr) begin
            m_full = 1'b0;
            for (int i = 0; i < 16; i++) m_bytes[i] = 8'h00;
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic f, input logic sr);
        logic [127:0] blk;
        in_valid    = v;
        in_byte     = b;
        flush       = f;
        state_ready = sr;
        @(posedge clk);
        #1;
        m_update(v, b, f, sr);
        chk("in_ready", in_ready, !m_full);
        chk("state_valid", state_valid, m_full);
        chk("byte_cnt", byte_cnt, m_cnt[3:0]);
        chk("state_data", state_data, m_pack());
        if (state_valid && !prev_sv) begin
            chk("sb_nonempty", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                blk = sb_q.pop_front();
                chk("sb_block", state_data, blk);
            end
        end
        prev_sv = state_valid;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_byte     = 8'h00;
        flush       = 1'b0;
        state_ready = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_state_valid"}, state_valid, 0);
        chk({tag, "_state_data"}, state_data, 0);
        chk({tag, "_byte_cnt"}, byte_cnt, 0);
        m_reset();
        prev_sv = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic stream16(input logic [7:0] base);
        for (int i = 0; i < 16; i++) step(1'b1, 8'(base + 8'(i)), 1'b0, 1'b0);
    endtask

    initial begin
        logic [127:0] held;
        int accepted;
        logic v;

        vecs[0]  = '{1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 128'h0};
        vecs[1]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 128'h0};
        vecs[2]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 128'h0};
        vecs[3]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1, 128'hA3A2A1A0};
        vecs[4]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 128'h0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 128'h000000A4_A3A2A1A0};
        vecs[6]  = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 128'h000000A4_A3A2A1A0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 128'h0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 128'h0};
        vecs[9]  = '{1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 128'h000000EE};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 128'h0};
        vecs[11] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 128'h00000077};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 128'h00000077};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 128'h0};

        idle_inputs();
        m_reset();
        prev_sv = 1'b0;
        rst_n = 1'b0;
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_state_valid", state_valid, 0);
        chk("rst_state_data", state_data, 0);
        chk("rst_byte_cnt", byte_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // gapless stream 0x00..0x0F
        stream16(8'h00);
        chk("full_data", state_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        chk("full_in_ready", in_ready, 0);
        held = state_data;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hFF, 1'b0, 1'b0);
            chk("hold_stable", state_data, held);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("handoff_valid", state_valid, 0);
        chk("handoff_clear", state_data, 0);
        chk("handoff_in_ready", in_ready, 1);

        // flush handling vectors
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].v, vecs[i].b, vecs[i].f, vecs[i].sr);
            chk($sformatf("vec%0d_valid", i), state_valid, vecs[i].exp_sv);
            chk($sformatf("vec%0d_cnt", i), byte_cnt, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_ready", i), in_ready, !vecs[i].exp_sv);
            if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), state_data, vecs[i].exp_d);
        end

        // random in_valid gaps on 0x10..0x1F
        accepted = 0;
        for (int c = 0; c < 200 && accepted < 16; c++) begin
            v = 1'($urandom_range(0, 1));
            step(v, 8'(8'h10 + 8'(accepted)), 1'b0, 1'b0);
            if (v) accepted++;
        end
        chk("rand_accepted", accepted, 16);
        chk("rand_data", state_data, 128'h1F1E1D1C_1B1A1918_17161514_13121110);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // reset mid-block then in FULL
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h20 + 8'(i)), 1'b0, 1'b0);
        chk("mid_cnt", byte_cnt, 9);
        async_reset("rst_mid");
        stream16(8'h30);
        chk("clean_block1", state_data, 128'h3F3E3D3C_3B3A3938_37363534_33323130);
        async_reset("rst_full");
        stream16(8'h40);
        chk("clean_block2", state_data, 128'h4F4E4D4C_4B4A4948_47464544_43424140);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        chk("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
